// File: rtl/sa_ctrl_pkg.sv
// Shared types and defaults for the systolic-array tile job controller.
package sa_ctrl_pkg;

  localparam int ROWS_DEF  = 8;
  localparam int LEN_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int timeout_default(input int rows);
    return rows * 4;
  endfunction

endpackage

// File: rtl/sa_tile_ctrl_perf.sv
// Saturating job-cycle and feed-stall counters; only built with SA_TILE_CTRL_PERF_EN.
module sa_tile_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        active,
  input  logic        stall,
  output logic [31:0] job_cyc,
  output logic [31:0] stall_cyc
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      job_cyc   <= '0;
      stall_cyc <= '0;
    end else if (start) begin
      job_cyc   <= '0;
      stall_cyc <= '0;
    end else begin
      if (active) job_cyc   <= sat_inc(job_cyc);
      if (stall)  stall_cyc <= sat_inc(stall_cyc);
    end
  end

endmodule

// File: rtl/sa_tile_ctrl.sv
// Job sequencer for the systolic-array core: feeds K beats, waits for all rows, pops the result.
// Optional perf counters are enabled with the SA_TILE_CTRL_PERF_EN macro.
module sa_tile_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = timeout_default(ROWS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             sa_inpvalid,
  input  logic [ROWS-1:0]  sa_rvalid,
  output logic             sa_outread,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [31:0]      perf_job_cyc,
  output logic [31:0]      perf_stall_cyc
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             all_v, accept, beat, last_beat, to_hit;

  assign all_v     = &sa_rvalid;
  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign beat      = (state == ST_FEED) && src_valid;
  assign last_beat = beat && (beat_cnt == len_q - LEN_W'(1));
  assign to_hit    = (to_cnt == TO_W'(TIMEOUT - 1));

  assign busy        = (state != ST_IDLE);
  assign sa_inpvalid = src_valid && src_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    src_ready  = 1'b0;
    res_valid  = 1'b0;
    sa_outread = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_len == '0) ? ST_DONE : ST_FEED;
      end
      ST_FEED: begin
        src_ready = 1'b1;
        if (last_beat) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A complete row set wins over a timeout landing in the same cycle.
        if (all_v)       state_nxt = ST_DRAIN;
        else if (to_hit) state_nxt = ST_DONE;
      end
      ST_DRAIN: begin
        res_valid = all_v;
        if (all_v && res_ready) begin
          sa_outread = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Job length is data-like: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) len_q <= cmd_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      to_cnt   <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= '0;
        to_cnt   <= '0;
        err      <= (cmd_len == '0);
      end
      if (beat && !last_beat) beat_cnt <= beat_cnt + LEN_W'(1);
      if (state == ST_WAIT) begin
        to_cnt <= all_v ? '0 : to_cnt + TO_W'(1);
        if (!all_v && to_hit) err <= 1'b1;
      end
      if (state == ST_DRAIN && !all_v) err <= 1'b1;
    end
  end

`ifdef SA_TILE_CTRL_PERF_EN
  sa_tile_ctrl_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .active    (busy),
    .stall     ((state == ST_FEED) && !src_valid),
    .job_cyc   (perf_job_cyc),
    .stall_cyc (perf_stall_cyc)
  );
`else
  assign perf_job_cyc   = '0;
  assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Bench for sa_tile_ctrl: job table plus random jobs checked against a job-timeline model.
module tb_sa_tile_ctrl;

  localparam int ROWS    = 8;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             src_valid, src_ready, sa_inpvalid;
  logic [ROWS-1:0]  sa_rvalid;
  logic             sa_outread, res_valid, res_ready, done, busy, err;
  logic [31:0]      perf_job_cyc, perf_stall_cyc;

  sa_tile_ctrl #(.ROWS(ROWS), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .src_valid(src_valid), .src_ready(src_ready), .sa_inpvalid(sa_inpvalid),
    .sa_rvalid(sa_rvalid), .sa_outread(sa_outread), .res_valid(res_valid),
    .res_ready(res_ready), .done(done), .busy(busy), .err(err),
    .perf_job_cyc(perf_job_cyc), .perf_stall_cyc(perf_stall_cyc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // Per-job signal trackers: mismatching cycles are tallied, one check per signal per job.
  localparam int NSIG = 8;
  string sig_name [NSIG] = '{"cmd_ready", "busy", "src_ready", "inpvalid",
                             "res_valid", "outread", "done", "err"};
  int   bad [NSIG];
  int   fst [NSIG];
  logic fg  [NSIG];
  logic fe  [NSIG];

  task automatic mark(input int idx, input logic got, input logic exp, input int c);
    if (got !== exp) begin
      if (bad[idx] == 0) begin
        fst[idx] = c; fg[idx] = got; fe[idx] = exp;
      end
      bad[idx]++;
    end
  endtask

  typedef struct {
    int          k;
    logic [31:0] pat;   // 0 = random src_valid pattern, else bits LSB first
    int          d;     // WAIT cycles before all rows come valid
    int          r;     // DRAIN cycles with res_ready low
    int          mode;  // 0 = rows complete after d, 1 = never any, 2 = rows 0-6 only
    bit          drop;  // one partial-rvalid cycle at DRAIN entry
    bit          exp_err;
  } job_t;

  function automatic logic [ROWS-1:0] partial_rv();
    logic [ROWS-1:0] v;
    v = ROWS'($urandom);
    v[$urandom_range(0, ROWS-1)] = 1'b0;
    return v;
  endfunction

  task automatic run_job(input job_t j, input int id);
    bit sv [0:1023];
    bit b, ok, in_feed;
    int f, ones, dr0, p, dn;
    string tag;
    for (int i = 0; i < NSIG; i++) bad[i] = 0;
    f = 0; ones = 0; dr0 = 0; p = 0;
    while (j.k > 0 && ones < j.k && f < 1000) begin
      f++;
      if (j.pat != 0) b = j.pat[(f-1) % 32];
      else            b = ($urandom_range(0, 99) < 60);
      sv[f] = b;
      if (b) ones++;
    end
    ok = (j.k > 0) && (j.mode == 0) && (j.d < TIMEOUT);
    if (j.k == 0) dn = 1;
    else if (ok) begin
      dr0 = f + 2 + j.d;
      p   = dr0 + ((j.drop && j.r < 1) ? 1 : j.r);
      dn  = p + 1;
    end else dn = f + TIMEOUT + 1;

    for (int c = 0; c <= dn + 1; c++) begin
      in_feed   = (j.k > 0) && (c >= 1) && (c <= f);
      cmd_valid = (c == 0) ? 1'b1 : ((c <= dn) ? 1'($urandom_range(0, 1)) : 1'b0);
      cmd_len   = (c == 0) ? LEN_W'(j.k) : LEN_W'($urandom);
      src_valid = in_feed ? sv[c] : 1'($urandom_range(0, 1));
      if (ok && c >= f + 1 + j.d && c <= p)
        sa_rvalid = (j.drop && c == dr0) ? partial_rv() : '1;
      else if (j.k > 0 && c > f && c < dn)
        sa_rvalid = (j.mode == 1) ? '0 : ((j.mode == 2) ? ROWS'(8'h7F) : partial_rv());
      else
        sa_rvalid = ROWS'($urandom);
      if (ok && c >= dr0 && c <= p) res_ready = (c == p);
      else                          res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      mark(0, cmd_ready,   (c == 0) || (c > dn), c);
      mark(1, busy,        (c >= 1) && (c <= dn), c);
      mark(2, src_ready,   in_feed, c);
      mark(3, sa_inpvalid, in_feed && sv[c], c);
      mark(4, res_valid,   ok && c >= dr0 && c <= p && !(j.drop && c == dr0), c);
      mark(5, sa_outread,  ok && c == p, c);
      mark(6, done,        c == dn, c);
      if (c == 1)  mark(7, err, j.k == 0, c);
      if (c >= dn) mark(7, err, j.exp_err, c);
      @(posedge clk); #1;
    end

    for (int i = 0; i < NSIG; i++) begin
      checks++;
      if (bad[i] != 0) begin
        errors++;
        $display("FAIL job%0d %s: %0d bad cycles, first at c=%0d got %b want %b",
                 id, sig_name[i], bad[i], fst[i], fg[i], fe[i]);
      end
    end
    tag = $sformatf("job%0d", id);
`ifdef SA_TILE_CTRL_PERF_EN
    chk({tag, " perf_job_cyc"},   perf_job_cyc,   32'(dn));
    chk({tag, " perf_stall_cyc"}, perf_stall_cyc, 32'(f - ones));
`else
    chk({tag, " perf_job_cyc"},   perf_job_cyc,   32'd0);
    chk({tag, " perf_stall_cyc"}, perf_stall_cyc, 32'd0);
`endif
  endtask

  job_t tbl [11];
  job_t rj;
  int   m;

  initial begin
    tbl[0]  = '{k:16, pat:32'hFFFFFFFF, d:20, r:0,  mode:0, drop:0, exp_err:0}; // basic
    tbl[1]  = '{k:4,  pat:32'h59,       d:3,  r:0,  mode:0, drop:0, exp_err:0}; // bubbles 1,0,0,1,1,0,1
    tbl[2]  = '{k:2,  pat:32'hFFFFFFFF, d:0,  r:0,  mode:1, drop:0, exp_err:1}; // timeout, no rvalid
    tbl[3]  = '{k:2,  pat:32'hFFFFFFFF, d:0,  r:0,  mode:2, drop:0, exp_err:1}; // timeout, rows 0-6
    tbl[4]  = '{k:3,  pat:32'hFFFFFFFF, d:2,  r:10, mode:0, drop:0, exp_err:0}; // backpressure
    tbl[5]  = '{k:0,  pat:32'h0,        d:0,  r:0,  mode:0, drop:0, exp_err:1}; // zero length
    tbl[6]  = '{k:1,  pat:32'h1,        d:0,  r:0,  mode:0, drop:0, exp_err:0}; // restart clears err
    tbl[7]  = '{k:2,  pat:32'hFFFFFFFF, d:31, r:1,  mode:0, drop:0, exp_err:0}; // rows on last WAIT cycle
    tbl[8]  = '{k:2,  pat:32'hFFFFFFFF, d:32, r:0,  mode:0, drop:0, exp_err:1}; // rows one cycle too late
    tbl[9]  = '{k:2,  pat:32'h5,        d:1,  r:3,  mode:0, drop:1, exp_err:1}; // rvalid drop in DRAIN
    tbl[10] = '{k:5,  pat:32'h0,        d:5,  r:2,  mode:0, drop:0, exp_err:0}; // random bubbles

    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; src_valid = 1'b1;
    sa_rvalid = '1; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst cmd_ready",   cmd_ready,   1);
    chk("rst busy",        busy,        0);
    chk("rst src_ready",   src_ready,   0);
    chk("rst inpvalid",    sa_inpvalid, 0);
    chk("rst res_valid",   res_valid,   0);
    chk("rst outread",     sa_outread,  0);
    chk("rst done",        done,        0);
    chk("rst err",         err,         0);
    chk("rst perf_job",    perf_job_cyc, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_job(tbl[i], i);

    // Reset in the middle of a 16-beat feed, then a clean job.
    cmd_valid = 1'b1; cmd_len = LEN_W'(16); src_valid = 1'b1; res_ready = 1'b0; sa_rvalid = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst feeding", sa_inpvalid, 1);
    @(posedge clk); #1;
    rst = 1'b0; sa_rvalid = '1; res_ready = 1'b1;
    @(negedge clk);
    chk("midrst cmd_ready", cmd_ready,   1);
    chk("midrst busy",      busy,        0);
    chk("midrst src_ready", src_ready,   0);
    chk("midrst inpvalid",  sa_inpvalid, 0);
    chk("midrst res_valid", res_valid,   0);
    chk("midrst outread",   sa_outread,  0);
    chk("midrst done",      done,        0);
    chk("midrst err",       err,         0);
    @(posedge clk); #1;
    run_job(tbl[0], 100);

    for (int i = 0; i < 20; i++) begin
      m       = $urandom_range(0, 4);
      rj.k    = $urandom_range(0, 12);
      rj.pat  = 32'h0;
      rj.d    = $urandom_range(0, 40);
      rj.r    = $urandom_range(0, 6);
      rj.mode = (m <= 2) ? 0 : m - 2;
      rj.drop = ($urandom_range(0, 5) == 0);
      rj.exp_err = !(rj.k > 0 && rj.mode == 0 && rj.d < TIMEOUT) || rj.drop;
      run_job(rj, 200 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sa_tile_ctrl.md
Name: sa_tile_ctrl

Overview:
Job sequencer for the systolic-array core. It accepts one job command (K input vector pairs), gates a source stream into the core's inpvalid, then waits for the all-row result set. It pops that set with outread once a downstream consumer is ready and reports done/error. Control-only: a/w data travel directly from the source to the core; this block only qualifies them.

Parameters:
ROWS, 8, array rows; width of the per-row result-valid vector.
LEN_W, 16, width of the job length field and the beat counter.
TIMEOUT, 32, maximum cycles from the last fed beat to an all-rows-valid result (default ROWS*4).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  job command offered.
cmd_ready  out  1  high only in IDLE.
cmd_len  in  LEN_W  number of vector pairs K to feed.
src_valid  in  1  a/w vector pair present at the core inputs.
src_ready  out  1  controller accepts the pair this cycle.
sa_inpvalid  out  1  to core; equals src_valid & src_ready.
sa_rvalid  in  ROWS  per-row result-valid vector from the core.
sa_outread  out  1  to core; one-cycle pop of the result set.
res_valid  out  1  full result set available to the consumer.
res_ready  in  1  consumer takes the result set.
done  out  1  one-cycle pulse at job end.
busy  out  1  high in any state other than IDLE.
err  out  1  sticky error; cleared on the next accepted command.

Behaviour:
- Reset: state=IDLE, beat/timeout counters=0, err=0; sa_inpvalid, sa_outread, res_valid, done, src_ready all 0; cmd_ready=1 from the first cycle after reset.
- Reset mid-job returns to IDLE at the next edge. The core is not reset by this block; stale sa_rvalid is ignored in IDLE.
- States: IDLE, FEED, WAIT, DRAIN, DONE.
- IDLE: on cmd_valid, latch cmd_len, clear err and counters.
  - cmd_len!=0 -> FEED.
  - cmd_len==0 -> err=1 -> DONE (no beats fed).
- FEED: src_ready=1.
  - Each cycle with src_valid=1 is a beat; beat counter increments.
  - src_valid=0 is a bubble: sa_inpvalid=0, no count, no timeout.
  - Beat with counter==K-1 -> WAIT. Exactly K beats are accepted; src_ready=0 outside FEED.
- WAIT: the timeout counter increments each cycle.
  - &sa_rvalid -> DRAIN, counter cleared.
  - Counter reaches TIMEOUT-1 without &sa_rvalid -> err=1 -> DONE. A partial sa_rvalid does not leave WAIT.
- DRAIN: res_valid = &sa_rvalid.
  - When res_valid & res_ready: sa_outread=1 for exactly that cycle -> DONE.
  - sa_outread is combinational from state, &sa_rvalid and res_ready.
  - res_ready held low stalls indefinitely; no timeout in DRAIN.
  - sa_rvalid dropping before the pop -> err=1, stay in DRAIN.
- DONE: done=1 for one cycle -> IDLE. cmd_ready=0 here, so a command presented in DONE is accepted the following cycle.
- Latency for K beats with no bubbles: FEED spans K cycles; the result appears when the core asserts rvalid; done follows the pop by one cycle.
- Counter width: beat counter LEN_W bits, never wraps (bounded by K ≤ 2^LEN_W−1); timeout counter $clog2(TIMEOUT) bits.

Optional Feature:
SA_TILE_CTRL_PERF_EN:
- Defined: adds 32-bit outputs perf_job_cyc (cycles from command accept to done) and perf_stall_cyc (FEED cycles with src_valid=0). Both clear on command accept, saturate at all-ones and hold after done.
- Undefined: both ports are present but tied to 0; no counter logic.

Decomposition:
- Package sa_ctrl_pkg holds:
  - the state enum (IDLE/FEED/WAIT/DRAIN/DONE);
  - default ROWS and LEN_W constants;
  - the TIMEOUT default expression.
- One natural sub-module: sa_tile_ctrl_perf (the perf counters), instantiated only under the macro. The FSM stays in the top.

Test Plan:
- Basic job: cmd_len=16, src_valid held 1, core model raises all 8 rvalid 20 cycles later, res_ready=1 -> sa_inpvalid high exactly 16 cycles; one sa_outread pulse; done one cycle after; err=0.
- Bubbles: cmd_len=4, src_valid pattern 1,0,0,1,1,0,1 -> exactly 4 sa_inpvalid pulses aligned to the 1s; FEED lasts 7 cycles; perf_stall_cyc=3 with macro.
- Timeout: cmd_len=2, rvalid never asserted (or only rows 0-6 asserted) -> err=1 after 32 WAIT cycles; done pulses; no sa_outread.
- Backpressure: full rvalid in DRAIN with res_ready low for 10 cycles -> res_valid held, sa_outread=0 throughout; res_ready=1 -> single sa_outread, done next cycle.
- Zero length and restart: cmd_len=0 -> no src_ready, err=1, done within 2 cycles; next cmd_len=1 clears err and completes normally.
- Mid-job reset: assert rst during FEED at beat 5 of 16 -> next cycle IDLE, cmd_ready=1, all outputs 0; a new job then runs cleanly.
